// File: rtl/hazard_unit_pkg.sv
// Shared encodings and helpers for the ID/EX hazard control block.
package hazard_unit_pkg;

    // controlRF encoding that selects memory data as the register-file source (a load)
    localparam logic [1:0] RF_SRC_MEM = 2'b01;

    // EX operand select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LSTALL   = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    // Pick the youngest in-flight producer of rs; MEM beats WB, x0 never forwards
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_mem,
        input logic       we_mem,
        input logic [4:0] rd_wb,
        input logic       we_wb
    );
        if (we_mem && rd_mem != 5'd0 && rd_mem == rs)
            return FWD_MEM;
        else if (we_wb && rd_wb != 5'd0 && rd_wb == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter clocked with the pipeline registers (negedge).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, sticking at all ones
    always_ff @(negedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (en && count != {W{1'b1}})
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall / taken-branch flush FSM and EX operand forwarding selects.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic             we_ex,
    input  logic             load_ex,
    input  logic             br_taken_ex,
    input  logic [4:0]       rd_mem,
    input  logic             we_mem,
    input  logic [4:0]       rd_wb,
    input  logic             we_wb,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Remaining-cycle reload values; the current cycle is the first one
    localparam logic [3:0] LD_INIT = 4'(LOAD_LAT - 1);
    localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       lu;
    logic       redirect_now, stall_now;

    assign lu = load_ex && we_ex && (rd_ex != 5'd0) &&
                ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));

    // State register, updated with the pipeline registers
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: a taken branch wins over a load-use in RUN and aborts an LSTALL
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (br_taken_ex) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_nx = REDIRECT;
                        cnt_nx   = FL_INIT;
                    end
                end else if (lu) begin
                    if (LOAD_LAT > 1) begin
                        state_nx = LSTALL;
                        cnt_nx   = LD_INIT;
                    end
                end
            end
            LSTALL: begin
                if (br_taken_ex) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_nx = REDIRECT;
                        cnt_nx   = FL_INIT;
                    end else begin
                        state_nx = RUN;
                    end
                end else if (cnt == 4'd1) begin
                    state_nx = RUN;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            REDIRECT: begin
                // EX holds a bubble here, so br_taken_ex cannot be real
                if (cnt == 4'd1)
                    state_nx = RUN;
                else
                    cnt_nx = cnt - 4'd1;
            end
            default: begin
                state_nx = RUN;
                cnt_nx   = '0;
            end
        endcase
    end

    // Control outputs; everything is held low while reset is asserted
    always_comb begin
        redirect_now = ((state == RUN) || (state == LSTALL)) && br_taken_ex;
        stall_now    = !br_taken_ex && (((state == RUN) && lu) || (state == LSTALL));
        stall_pc     = rst && stall_now;
        stall_ifid   = rst && stall_now;
        flush_ifid   = rst && (redirect_now || (state == REDIRECT));
        bubble_idex  = rst && (stall_now || redirect_now || (state == REDIRECT));
        fwd_a        = rst ? fwd_sel(rs1_ex, rd_mem, we_mem, rd_wb, we_wb) : FWD_RF;
        fwd_b        = rst ? fwd_sel(rs2_ex, rd_mem, we_mem, rd_wb, we_wb) : FWD_RF;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_pc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_ifid),
        .count (flush_cnt)
    );

endmodule
